fdiv_issue_ctrl: RTL and testbench
==================================

// Module: fdiv_issue_ctrl
// PURPOSE
// - Sequential issue/retire wrapper around the combinational Newton-Raphson FP32 divider (Division).
// - Accepts a/b operand pairs over valid/ready and resolves IEEE special cases locally.
// - Holds operands stable on the divider inputs for a fixed multicycle window, then captures the quotient.
// - Returns result plus exception flags over valid/ready to the FPU writeback path.
// PARAMETERS
// - MC_CYCLES  default 4  cycles the divider path is allowed to settle (multicycle constraint); legal range 1..15
// PORTS
// - clk         in   1   system clock, rising edge
// - rst         in   1   asynchronous reset, active-high
// - in_valid    in   1   request valid
// - in_ready    out  1   block can accept a request
// - in_x        in   32  dividend, FP32
// - in_y        in   32  divisor, FP32
// - out_valid   out  1   result valid
// - out_ready   in   1   consumer accepts result
// - out_result  out  32  quotient, FP32
// - out_flags   out  3   {overflow, divzero, invalid}
// - div_x       out  32  dividend to divider (registered)
// - div_y       out  32  divisor to divider (registered)
// - div_result  in   32  quotient from divider (combinational path)
// - busy        out  1   state != IDLE
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE; out_valid 0, out_result 0, out_flags 0, div_x/div_y 0, counter 0; an in-flight op is dropped with no output.
// - States: IDLE -> (accept, special) DONE | (accept, normal) CALC; CALC -> DONE when counter==0; DONE -> IDLE on out_valid&&out_ready.
// - in_ready = (state==IDLE); out_valid = (state==DONE). No accept in the same cycle as an output handshake.
// - On accept: register in_x/in_y into div_x/div_y; they stay constant until the next accept.
// - Classification: exp==0xFF with mant!=0 is NaN; exp==0xFF with mant==0 is inf; exp==0 is zero (denormals flushed); all other values are finite.
// - Special results (sign s = x[31]^y[31]); rows below are checked in priority order:
//   - NaN in either operand -> 0x7FC00000, flags 000.
//   - inf/inf or 0/0 -> 0x7FC00000, invalid=1.
//   - finite-nonzero/0 -> {s,0x7F800000[30:0]}, divzero=1.
//   - inf/finite or inf/0 -> signed inf, flags 000.
//   - finite/inf or 0/nonzero -> signed zero, flags 000.
// - Special latency: out_valid is high the cycle after the accept edge.
// - Normal path: counter loads MC_CYCLES-1 on the accept edge and decrements in CALC.
// - On the edge where counter==0: out_result = {s, div_result[30:0]}; overflow=1 iff div_result[30:23]==8'hFF, then out_result = signed inf.
// - Normal latency: out_valid is high MC_CYCLES+1 cycles after accept.
// - DONE holds out_result/out_flags stable while out_ready=0 (no timeout).
// - out_result/out_flags retain their last value after the handshake.
// - in_x/in_y changes outside the accept edge have no effect.
// STRUCTURE
// - fdiv_pkg:
//   - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
//   - QNAN=32'h7FC00000, PINF=32'h7F800000
//   - flag bit indices FLG_INV=0, FLG_DZ=1, FLG_OVF=2
// - Sub-module fp32_classify (combinational): in 32b -> is_nan, is_inf, is_zero, sign.
//   - Instantiated twice, once for x and once for y.
// - The Division instance lives in the parent FPU; this block only drives and samples it.
// TESTING
// - 6.0/1.5 (0x40C00000/0x3FC00000), div model returns 0x40800000 -> out_result 0x40800000, flags 000, out_valid at accept+5 (MC_CYCLES=4).
// - 1.0/0.0 and -1.0/0.0 -> 0x7F800000 / 0xFF800000, flags 010, out_valid at accept+1; divider output ignored.
// - 0/0, inf/inf, NaN/2.0 -> 0x7FC00000 with flags 001, 001, 000 respectively.
// - -3.0/inf -> 0x80000000; inf/-2.0 -> 0xFF800000; flags 000.
// - out_ready held 0 for 10 cycles in DONE:
//   - result and flags stay stable, in_ready stays 0, a new in_valid is not accepted;
//   - release -> in_ready=1 the next cycle.
// - rst pulsed mid-CALC -> out_valid 0 and all outputs 0 immediately; no stale result after reset; next request completes normally.

Source files
------------

// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared state encoding, FP32 constants and flag bit positions for the divider issue control
package fdiv_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam int FLG_INV = 0;
    localparam int FLG_DZ = 1;
    localparam int FLG_OVF = 2;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: FP32 operand classification with denormals treated as zero
module fp32_classify (
    input  logic [31:0] val,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero,
    output logic        sign
);
    assign is_nan = &val[30:23] && |val[22:0];
    assign is_inf = &val[30:23] && ~|val[22:0];
    assign is_zero = ~|val[30:23];
    assign sign = val[31];
endmodule

// File: rtl/fdiv_issue_ctrl.sv
// fdiv_issue_ctrl: issues operands to a multicycle combinational FP32 divider, resolves special cases locally
module fdiv_issue_ctrl
    import fdiv_pkg::*;
#(
    parameter int MC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [31:0] div_result,
    output logic        busy
);
    state_t state, state_nx;
    logic [3:0] cnt;
    logic xn, xi, xz, xs, yn, yi, yz, ys;
    logic acc, special, s_in, s_dv, ovf, nan_in, inv_in, dz_in;
    logic [31:0] sp_res;
    logic [2:0] sp_flg;
    fp32_classify u_cx (.val(in_x), .is_nan(xn), .is_inf(xi), .is_zero(xz), .sign(xs));
    fp32_classify u_cy (.val(in_y), .is_nan(yn), .is_inf(yi), .is_zero(yz), .sign(ys));
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign acc = in_valid && in_ready;
    assign special = xn | yn | xi | yi | xz | yz;
    assign s_in = xs ^ ys;
    assign s_dv = div_x[31] ^ div_y[31];
    assign ovf = &div_result[30:23];
    assign nan_in = xn | yn;
    assign inv_in = (xi & yi) | (xz & yz);
    assign dz_in = yz & ~xi;
    // remaining rows after NaN/invalid: any x/0 or inf/x is signed inf, everything else signed zero
    assign sp_res = nan_in || inv_in ? QNAN : yz || xi ? {s_in, PINF[30:0]} : {s_in, 31'd0};
    assign sp_flg = nan_in ? 3'd0 : inv_in ? 3'(1 << FLG_INV) : dz_in ? 3'(1 << FLG_DZ) : 3'd0;
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (acc ? (special ? DONE : CALC) : IDLE)
                 : state == CALC ? (cnt == 4'd0 ? DONE : CALC)
                 : state == DONE ? (out_ready ? IDLE : DONE)
                 : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
            div_x <= 32'd0;
            div_y <= 32'd0;
            out_result <= 32'd0;
            out_flags <= 3'd0;
        end else begin
            if (acc) begin
                div_x <= in_x;
                div_y <= in_y;
                cnt <= 4'(MC_CYCLES - 1);
            end else if (state == CALC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (acc && special) begin
                out_result <= sp_res;
                out_flags <= sp_flg;
            end else if (state == CALC && cnt == 4'd0) begin
                out_result <= ovf ? {s_dv, PINF[30:0]} : {s_dv, div_result[30:0]};
                out_flags <= ovf ? 3'(1 << FLG_OVF) : 3'd0;
            end
        end
    end
endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// tb_fdiv_issue_ctrl: scoreboard bench for fdiv_issue_ctrl with a lookup divider model
module tb_fdiv_issue_ctrl;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [31:0] in_x = 0, in_y = 0, op_x = 0, op_y = 0, div_val = 0;
    logic in_ready, out_valid, busy;
    logic [31:0] out_result, div_x, div_y, div_result;
    logic [2:0] out_flags;
    int n_cmp = 0, n_bad = 0;
    logic [34:0] sb_q[$];
    always #5 clk = ~clk;
    assign div_result = (div_x == op_x && div_y == op_y) ? div_val : 32'hDEADBEEF;
    fdiv_issue_ctrl #(.MC_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .div_x(div_x), .div_y(div_y),
        .div_result(div_result), .busy(busy)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
            else begin
                logic [34:0] e;
                e = sb_q.pop_front();
                chk("result", out_result, e[34:3]);
                chk("flags", 32'(out_flags), 32'(e[2:0]));
            end
        end
    end
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [31:0] dv,
                        input logic [31:0] res, input logic [2:0] flg, input int lat, input bit hold);
        int n;
        chk("in_ready_pre", 32'(in_ready), 32'd1);
        op_x = x; op_y = y; div_val = dv;
        in_x = x; in_y = y; in_valid = 1;
        sb_q.push_back({res, flg});
        if (hold) out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0; in_x = $urandom; in_y = $urandom;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        if (hold) begin
            in_valid = 1; in_x = 32'h3F800000; in_y = 32'h40000000;
            repeat (10) begin
                @(posedge clk); #1;
                chk("hold_res", out_result, res);
                chk("hold_flg", 32'(out_flags), 32'(flg));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
                chk("hold_out_valid", 32'(out_valid), 32'd1);
                chk("hold_div_x", div_x, x);
            end
            in_valid = 0; out_ready = 1;
        end
        @(posedge clk); #1;
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_res_kept", out_result, res);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_div_x", div_x, 32'd0);
        rst = 0;
        @(posedge clk); #1;
        send(32'h40C00000, 32'h3FC00000, 32'h40800000, 32'h40800000, 3'b000, 5, 0);
        send(32'hC0C00000, 32'h3FC00000, 32'h40800000, 32'hC0800000, 3'b000, 5, 0);
        send(32'h40C00000, 32'h3FC00000, 32'hC0800000, 32'h40800000, 3'b000, 5, 0);
        send(32'hC0000000, 32'h00800000, 32'h7F800000, 32'hFF800000, 3'b100, 5, 0);
        send(32'h40000000, 32'h00800000, 32'h7FFFFFFF, 32'h7F800000, 3'b100, 5, 0);
        send(32'h3F800000, 32'h00000000, 32'h12345678, 32'h7F800000, 3'b010, 1, 0);
        send(32'hBF800000, 32'h00000000, 32'h12345678, 32'hFF800000, 3'b010, 1, 0);
        send(32'h00000000, 32'h00000000, 32'h12345678, 32'h7FC00000, 3'b001, 1, 0);
        send(32'h00000001, 32'h80000000, 32'h12345678, 32'h7FC00000, 3'b001, 1, 0);
        send(32'h7F800000, 32'hFF800000, 32'h12345678, 32'h7FC00000, 3'b001, 1, 0);
        send(32'h7FC00001, 32'h40000000, 32'h12345678, 32'h7FC00000, 3'b000, 1, 0);
        send(32'h7F800001, 32'h00000000, 32'h12345678, 32'h7FC00000, 3'b000, 1, 0);
        send(32'hC0400000, 32'h7F800000, 32'h12345678, 32'h80000000, 3'b000, 1, 0);
        send(32'h7F800000, 32'hC0000000, 32'h12345678, 32'hFF800000, 3'b000, 1, 0);
        send(32'hFF800000, 32'h00000000, 32'h12345678, 32'hFF800000, 3'b000, 1, 0);
        send(32'h00000000, 32'hC0000000, 32'h12345678, 32'h80000000, 3'b000, 1, 0);
        send(32'h40C00000, 32'h3FC00000, 32'h40800000, 32'h40800000, 3'b000, 5, 1);
        send(32'h3F800000, 32'h00000000, 32'h12345678, 32'h7F800000, 3'b010, 1, 1);
        op_x = 32'h40C00000; op_y = 32'h3FC00000; div_val = 32'h40800000;
        in_x = op_x; in_y = op_y; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        chk("calc_busy", 32'(busy), 32'd1);
        rst = 1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", out_result, 32'd0);
        chk("mid_rst_flags", 32'(out_flags), 32'd0);
        chk("mid_rst_div_x", div_x, 32'd0);
        chk("mid_rst_div_y", div_y, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        repeat (8) begin
            @(posedge clk); #1;
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        send(32'h40C00000, 32'h3FC00000, 32'h40800000, 32'h40800000, 3'b000, 5, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
